// File: rtl/div_feeder_pkg.sv
`default_nettype none
//==============================================================================
// div_feeder_pkg : shared widths, response record and divide-by-zero constant.
// Rev 1.0
//==============================================================================
package div_feeder_pkg;

  localparam int DIV_WIDTH = 20;
  localparam int DIV_TAG_W = 4;

  localparam logic [DIV_WIDTH-1:0] DIV_DBZ_QUOTIENT = '1;

  typedef struct packed {
    logic [DIV_WIDTH-1:0] quotient;
    logic [DIV_WIDTH-1:0] fractional;
    logic [DIV_TAG_W-1:0] tag;
    logic                 dbz;
  } div_rsp_t;

endpackage
`default_nettype wire

// File: rtl/div_feeder_if.sv
`default_nettype none
//==============================================================================
// div_feeder_if : request, divider and response signals of div_feeder.
// Rev 1.0
//==============================================================================
interface div_feeder_if
  import div_feeder_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int TAG_W = DIV_TAG_W,
  parameter int CNT_W = 6
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_dividend;
  logic [WIDTH-1:0] req_divisor;
  logic [TAG_W-1:0] req_tag;

  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_rfd;
  logic [WIDTH-1:0] div_quotient;
  logic [WIDTH-1:0] div_fractional;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_quotient;
  logic [WIDTH-1:0] rsp_fractional;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_dbz;

  logic [CNT_W-1:0] inflight;

  // Feeder side
  modport master (
    input  req_valid, req_dividend, req_divisor, req_tag,
    output req_ready,
    output div_dividend, div_divisor,
    input  div_rfd, div_quotient, div_fractional,
    output rsp_valid, rsp_quotient, rsp_fractional, rsp_tag, rsp_dbz,
    input  rsp_ready,
    output inflight
  );

  // Requester, divider and consumer side
  modport slave (
    output req_valid, req_dividend, req_divisor, req_tag,
    input  req_ready,
    input  div_dividend, div_divisor,
    output div_rfd, div_quotient, div_fractional,
    input  rsp_valid, rsp_quotient, rsp_fractional, rsp_tag, rsp_dbz,
    output rsp_ready,
    input  inflight
  );

endinterface
`default_nettype wire

// File: rtl/div_feeder_fifo.sv
`default_nettype none
//==============================================================================
// div_feeder_fifo : synchronous show-ahead FIFO of div_rsp_t with occupancy.
// Rev 1.0
//==============================================================================
module div_feeder_fifo
  import div_feeder_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  div_rsp_t                 wr_data_i,
  input  logic                     rd_en_i,
  output logic                     rd_valid_o,
  output div_rsp_t                 rd_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  div_rsp_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             w_rd;

  assign rd_valid_o = (count_q != '0);
  assign w_rd       = rd_en_i && rd_valid_o;

  // Zero the head while empty so the response outputs read 0 out of reset.
  assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o    = count_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en_i) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (w_rd) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (wr_en_i && !w_rd) begin
      count_d = count_q + (PTR_W + 1)'(1);
    end else if (!wr_en_i && w_rd) begin
      count_d = count_q - (PTR_W + 1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_feeder.sv
`default_nettype none
//==============================================================================
// div_feeder : credit-gated issue front end for the pipelined ip_div core.
// Optional divide-by-zero override: define DIV_FEEDER_ZERO_CHK_EN.  Rev 1.0
//==============================================================================
module div_feeder
  import div_feeder_pkg::*;
#(
  parameter int WIDTH   = DIV_WIDTH,
  parameter int LATENCY = 24,
  parameter int DEPTH   = 32,
  parameter int TAG_W   = DIV_TAG_W
) (
  input  logic          clk,
  input  logic          rst_n,
  div_feeder_if.master  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + DEPTH + 1);

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
`ifdef DIV_FEEDER_ZERO_CHK_EN
    logic             dbz;
`endif
  } side_t;

  side_t [LATENCY:0] side_q;
  side_t             side_d;
  logic [WIDTH-1:0]  dividend_q, dividend_d;
  logic [WIDTH-1:0]  divisor_q, divisor_d;
  logic [CNT_W-1:0]  pipe_cnt_q, pipe_cnt_d;

  logic [PTR_W:0]    w_fifo_cnt;
  logic [CNT_W-1:0]  w_used;
  logic              w_req_ready;
  logic              w_issue;
  logic              w_capture;
  div_rsp_t          w_cap_data;
  div_rsp_t          w_head;
  logic              w_head_valid;

  // Every slot in the divider pipe already owns a FIFO entry, so capture never overflows.
  assign w_used      = pipe_cnt_q + CNT_W'(w_fifo_cnt);
  assign w_req_ready = bus.div_rfd && (w_used < CNT_W'(DEPTH));
  assign w_issue     = bus.req_valid && w_req_ready;
  assign w_capture   = side_q[LATENCY].vld;

  always_comb begin
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    if (w_issue) begin
      dividend_d = bus.req_dividend;
      divisor_d  = bus.req_divisor;
    end
  end

  always_comb begin
    side_d     = '0;
    side_d.vld = w_issue;
    side_d.tag = bus.req_tag;
`ifdef DIV_FEEDER_ZERO_CHK_EN
    side_d.dbz = (bus.req_divisor == '0);
`endif
  end

  always_comb begin
    pipe_cnt_d = pipe_cnt_q;
    if (w_issue && !w_capture) begin
      pipe_cnt_d = pipe_cnt_q + CNT_W'(1);
    end else if (!w_issue && w_capture) begin
      pipe_cnt_d = pipe_cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      side_q     <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      pipe_cnt_q <= '0;
    end else begin
      side_q     <= {side_q[LATENCY-1:0], side_d};
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      pipe_cnt_q <= pipe_cnt_d;
    end
  end

  always_comb begin
    w_cap_data            = '0;
    w_cap_data.quotient   = bus.div_quotient;
    w_cap_data.fractional = bus.div_fractional;
    w_cap_data.tag        = side_q[LATENCY].tag;
`ifdef DIV_FEEDER_ZERO_CHK_EN
    // Whatever the divider produced for a zero divisor is discarded.
    if (side_q[LATENCY].dbz) begin
      w_cap_data.quotient   = DIV_DBZ_QUOTIENT;
      w_cap_data.fractional = '0;
      w_cap_data.dbz        = 1'b1;
    end
`endif
  end

  div_feeder_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en_i    (w_capture),
    .wr_data_i  (w_cap_data),
    .rd_en_i    (bus.rsp_ready),
    .rd_valid_o (w_head_valid),
    .rd_data_o  (w_head),
    .count_o    (w_fifo_cnt)
  );

  assign bus.req_ready      = w_req_ready;
  assign bus.div_dividend   = dividend_q;
  assign bus.div_divisor    = divisor_q;
  assign bus.rsp_valid      = w_head_valid;
  assign bus.rsp_quotient   = w_head.quotient;
  assign bus.rsp_fractional = w_head.fractional;
  assign bus.rsp_tag        = w_head.tag;
  assign bus.rsp_dbz        = w_head.dbz;
  assign bus.inflight       = w_used;

endmodule
`default_nettype wire
